// File: rtl/pwm_setpoint_sequencer.sv
// pwm_setpoint_sequencer: update controller for one half-bridge PWM generator.
// Owns the period tick counter, validates highside/lowside setpoints and runs the
// invalidate -> load -> wait-complete sequence once per period. Generator errors and
// completion timeouts latch FAULT, which forces zero on-times until cleared.
// Optional feature: define PWM_SETPOINT_SLEW_LIMIT_EN to limit each update's change
// per channel to max_step ticks; otherwise each update loads the target directly.
module pwm_setpoint_sequencer #(
  parameter int unsigned tick_count_period  = 100,
  parameter int unsigned bitwidth           = $clog2(tick_count_period) + 1,
  parameter int unsigned update_tick        = 10,
  parameter int unsigned max_step           = 4,
  parameter int unsigned completion_timeout = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                setpoint_valid,
  output logic                setpoint_ready,
  input  logic [bitwidth-1:0] setpoint_highside,
  input  logic [bitwidth-1:0] setpoint_lowside,
  output logic                setpoint_error,
  output logic [bitwidth-1:0] tick_counter,
  output logic [bitwidth-1:0] tick_count_highside,
  output logic [bitwidth-1:0] tick_count_lowside,
  output logic                invalidate_input_values,
  output logic                load_input_values,
  input  logic                calculation_complete,
  input  logic                calculation_error,
  input  logic                shortcircuit_error,
  input  logic                fault_clear,
  output logic                busy,
  output logic                fault,
  output logic                at_target
);

  localparam int unsigned SUM_W = bitwidth + 1;
  localparam int unsigned TO_W  = $clog2(completion_timeout) + 1;

  localparam logic [SUM_W-1:0]    PERIOD_SUM  = SUM_W'(tick_count_period);
  localparam logic [bitwidth-1:0] LAST_TICK   = bitwidth'(tick_count_period - 1);
  localparam logic [bitwidth-1:0] UPDATE_TICK = bitwidth'(update_tick);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(completion_timeout - 1);

  // The whole update sequence must finish well inside one period.
  if (update_tick + 3 + completion_timeout >= tick_count_period - 1) begin : g_bad_timing
    $error("update_tick + 3 + completion_timeout must be below tick_count_period - 1");
  end
  if (max_step == 0) begin : g_bad_step
    $error("max_step must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INVALIDATE,
    ST_LOAD,
    ST_WAIT_COMPLETE,
    ST_FAULT
  } state_t;

  state_t              state;
  logic [bitwidth-1:0] target_hs;
  logic [bitwidth-1:0] target_ls;
  logic [bitwidth-1:0] snap_hs;
  logic [bitwidth-1:0] snap_ls;
  logic [TO_W-1:0]     timeout_cnt;

  logic [SUM_W-1:0]    sp_sum;
  logic                sp_accept;
  logic                sp_bad;
  logic [bitwidth-1:0] target_hs_nxt;
  logic [bitwidth-1:0] target_ls_nxt;
  logic [bitwidth-1:0] next_hs;
  logic [bitwidth-1:0] next_ls;
  logic                launch;
  logic                gen_error;

  // Setpoint handshake: validate the offered pair and form the next target.
  always_comb begin
    sp_sum        = SUM_W'(setpoint_highside) + SUM_W'(setpoint_lowside);
    sp_accept     = setpoint_valid & setpoint_ready;
    sp_bad        = sp_sum > PERIOD_SUM;
    target_hs_nxt = target_hs;
    target_ls_nxt = target_ls;
    if (sp_accept && !sp_bad) begin
      target_hs_nxt = setpoint_highside;
      target_ls_nxt = setpoint_lowside;
    end
  end

`ifdef PWM_SETPOINT_SLEW_LIMIT_EN
  localparam logic [bitwidth-1:0] MAX_STEP = bitwidth'(max_step);

  function automatic logic [bitwidth-1:0] step_toward(input logic [bitwidth-1:0] cur,
                                                      input logic [bitwidth-1:0] tgt);
    logic [bitwidth-1:0] diff;
    if (tgt >= cur) begin
      diff        = tgt - cur;
      step_toward = (diff > MAX_STEP) ? cur + MAX_STEP : tgt;
    end else begin
      diff        = cur - tgt;
      step_toward = (diff > MAX_STEP) ? cur - MAX_STEP : tgt;
    end
  endfunction

  // Slew-limited step from the driven value toward the launch snapshot.
  assign next_hs = step_toward(tick_count_highside, snap_hs);
  assign next_ls = step_toward(tick_count_lowside, snap_ls);
`else
  // Direct load of the launch snapshot.
  assign next_hs = snap_hs;
  assign next_ls = snap_ls;
`endif

  assign launch = enable && (tick_counter == UPDATE_TICK) &&
                  ((tick_count_highside != target_hs) || (tick_count_lowside != target_ls));
  assign gen_error = calculation_error | shortcircuit_error;

  // Period tick counter; parked at 0 while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_counter <= '0;
    end else if (!enable || (tick_counter == LAST_TICK)) begin
      tick_counter <= '0;
    end else begin
      tick_counter <= tick_counter + bitwidth'(1);
    end
  end

  // Update sequencer FSM with registered outputs and target bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= ST_IDLE;
      target_hs               <= '0;
      target_ls               <= '0;
      snap_hs                 <= '0;
      snap_ls                 <= '0;
      timeout_cnt             <= '0;
      setpoint_ready          <= 1'b0;
      setpoint_error          <= 1'b0;
      tick_count_highside     <= '0;
      tick_count_lowside      <= '0;
      invalidate_input_values <= 1'b0;
      load_input_values       <= 1'b0;
      busy                    <= 1'b0;
      fault                   <= 1'b0;
      at_target               <= 1'b0;
    end else begin
      invalidate_input_values <= 1'b0;
      load_input_values       <= 1'b0;
      setpoint_error          <= sp_accept & sp_bad;
      setpoint_ready          <= 1'b1;
      target_hs               <= target_hs_nxt;
      target_ls               <= target_ls_nxt;

      if (gen_error) begin
        // Generator errors override everything, including a pending clear.
        state               <= ST_FAULT;
        tick_count_highside <= '0;
        tick_count_lowside  <= '0;
        busy                <= 1'b0;
        fault               <= 1'b1;
        at_target           <= 1'b0;
        setpoint_ready      <= 1'b0;
        timeout_cnt         <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (launch) begin
              // Snapshot the target so a setpoint accepted now waits a period.
              state                   <= ST_INVALIDATE;
              snap_hs                 <= target_hs;
              snap_ls                 <= target_ls;
              invalidate_input_values <= 1'b1;
              busy                    <= 1'b1;
              at_target               <= 1'b0;
            end else begin
              at_target <= (tick_count_highside == target_hs_nxt) &&
                           (tick_count_lowside == target_ls_nxt);
            end
          end
          ST_INVALIDATE: begin
            state               <= ST_LOAD;
            tick_count_highside <= next_hs;
            tick_count_lowside  <= next_ls;
            load_input_values   <= 1'b1;
          end
          ST_LOAD: begin
            state       <= ST_WAIT_COMPLETE;
            timeout_cnt <= '0;
          end
          ST_WAIT_COMPLETE: begin
            if (calculation_complete) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              at_target <= (tick_count_highside == target_hs_nxt) &&
                           (tick_count_lowside == target_ls_nxt);
            end else if (timeout_cnt == TO_LAST) begin
              state               <= ST_FAULT;
              tick_count_highside <= '0;
              tick_count_lowside  <= '0;
              busy                <= 1'b0;
              fault               <= 1'b1;
              setpoint_ready      <= 1'b0;
            end else begin
              timeout_cnt <= timeout_cnt + TO_W'(1);
            end
          end
          ST_FAULT: begin
            setpoint_ready <= 1'b0;
            if (fault_clear) begin
              state          <= ST_IDLE;
              fault          <= 1'b0;
              target_hs      <= '0;
              target_ls      <= '0;
              setpoint_ready <= 1'b1;
              at_target      <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_setpoint_sequencer.sv
// Self-checking bench for pwm_setpoint_sequencer (default parameters).
// Expected generator loads are pushed to a scoreboard queue when a setpoint is offered
// and popped when the DUT pulses load_input_values.
`timescale 1ns/1ps
module tb_pwm_setpoint_sequencer;

  localparam int unsigned BW = 8;
`ifdef PWM_SETPOINT_SLEW_LIMIT_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1000;
`endif

  typedef struct {
    logic [BW-1:0] hs;
    logic [BW-1:0] ls;
  } upd_t;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          setpoint_valid;
  logic          setpoint_ready;
  logic [BW-1:0] setpoint_highside;
  logic [BW-1:0] setpoint_lowside;
  logic          setpoint_error;
  logic [BW-1:0] tick_counter;
  logic [BW-1:0] tick_count_highside;
  logic [BW-1:0] tick_count_lowside;
  logic          invalidate_input_values;
  logic          load_input_values;
  logic          calculation_complete;
  logic          calculation_error;
  logic          shortcircuit_error;
  logic          fault_clear;
  logic          busy;
  logic          fault;
  logic          at_target;

  int checks = 0;
  int errors = 0;
  upd_t exp_q[$];
  logic [BW-1:0] m_hs, m_ls, m_thi, m_tlo;

  pwm_setpoint_sequencer dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .setpoint_valid(setpoint_valid),
    .setpoint_ready(setpoint_ready),
    .setpoint_highside(setpoint_highside),
    .setpoint_lowside(setpoint_lowside),
    .setpoint_error(setpoint_error),
    .tick_counter(tick_counter),
    .tick_count_highside(tick_count_highside),
    .tick_count_lowside(tick_count_lowside),
    .invalidate_input_values(invalidate_input_values),
    .load_input_values(load_input_values),
    .calculation_complete(calculation_complete),
    .calculation_error(calculation_error),
    .shortcircuit_error(shortcircuit_error),
    .fault_clear(fault_clear),
    .busy(busy),
    .fault(fault),
    .at_target(at_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BW-1:0] model_step(input logic [BW-1:0] cur, input logic [BW-1:0] tgt);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > STEP) return cur + BW'(STEP);
    if (d < -STEP) return cur - BW'(STEP);
    return tgt;
  endfunction

  task automatic offer(input logic [BW-1:0] hs, input logic [BW-1:0] ls);
    setpoint_highside = hs;
    setpoint_lowside  = ls;
    setpoint_valid    = 1'b1;
    tick();
    setpoint_valid    = 1'b0;
  endtask

  task automatic wait_invalidate(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (invalidate_input_values === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic complete_after(input int n);
    repeat (n - 1) tick();
    calculation_complete = 1'b1;
    tick();
    calculation_complete = 1'b0;
  endtask

  task automatic push_next();
    upd_t e;
    e.hs = model_step(m_hs, m_thi);
    e.ls = model_step(m_ls, m_tlo);
    exp_q.push_back(e);
  endtask

  // Runs update periods until the model reaches the target, checking every load.
  task automatic run_to_target(input int max_updates);
    upd_t a;
    bit seen;
    for (int u = 0; u < max_updates; u++) begin
      if (m_hs == m_thi && m_ls == m_tlo) break;
      push_next();
      wait_invalidate(seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL update_launch: no invalidate within 250 cycles, required one");
        exp_q.delete();
        return;
      end
      checks++;
      if (tick_counter !== 8'd11) begin
        errors++;
        $display("FAIL invalidate_tick: tick_counter=%0d, required 11", tick_counter);
      end
      tick();
      checks++;
      if (load_input_values !== 1'b1 || invalidate_input_values !== 1'b0 || tick_counter !== 8'd12) begin
        errors++;
        $display("FAIL load_pulse: load=%b inv=%b tick=%0d, required 1 0 12",
                 load_input_values, invalidate_input_values, tick_counter);
      end
      a = exp_q.pop_front();
      checks++;
      if (tick_count_highside !== a.hs || tick_count_lowside !== a.ls) begin
        errors++;
        $display("FAIL update_value: hs=%0d ls=%0d, required %0d %0d",
                 tick_count_highside, tick_count_lowside, a.hs, a.ls);
      end
      checks++;
      if ((9'(tick_count_highside) + 9'(tick_count_lowside)) > 9'd100) begin
        errors++;
        $display("FAIL sum_invariant: hs+ls=%0d, required <= 100",
                 9'(tick_count_highside) + 9'(tick_count_lowside));
      end
      m_hs = a.hs;
      m_ls = a.ls;
      complete_after(6);
      checks++;
      if (busy !== 1'b0 || at_target !== ((m_hs == m_thi) && (m_ls == m_tlo))) begin
        errors++;
        $display("FAIL after_complete: busy=%b at_target=%b, required 0 %b",
                 busy, at_target, (m_hs == m_thi) && (m_ls == m_tlo));
      end
    end
    checks++;
    if (tick_count_highside !== m_thi || tick_count_lowside !== m_tlo || at_target !== 1'b1) begin
      errors++;
      $display("FAIL reach_target: hs=%0d ls=%0d at_target=%b, required %0d %0d 1",
               tick_count_highside, tick_count_lowside, at_target, m_thi, m_tlo);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (setpoint_ready !== 1'b0 || tick_counter !== 8'd0 || tick_count_highside !== 8'd0 ||
        tick_count_lowside !== 8'd0 || busy !== 1'b0 || fault !== 1'b0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b tick=%0d hs=%0d ls=%0d busy=%b fault=%b at=%b, required all 0",
               setpoint_ready, tick_counter, tick_count_highside, tick_count_lowside, busy, fault, at_target);
    end
    #2 reset = 1'b1;
    tick();
    checks++;
    if (setpoint_ready !== 1'b1 || at_target !== 1'b1 || tick_counter !== 8'd0) begin
      errors++;
      $display("FAIL post_reset: ready=%b at_target=%b tick=%0d, required 1 1 0",
               setpoint_ready, at_target, tick_counter);
    end
    m_hs = '0; m_ls = '0; m_thi = '0; m_tlo = '0;
  endtask

  task automatic test_direct_update();
    offer(8'd40, 8'd50);
    m_thi = 8'd40; m_tlo = 8'd50;
    checks++;
    if (setpoint_error !== 1'b0) begin
      errors++;
      $display("FAIL accept_40_50: setpoint_error=%b, required 0", setpoint_error);
    end
    enable = 1'b1;
    run_to_target(20);
  endtask

  task automatic test_reject();
    int n_inv;
    int n_err;
    offer(8'd60, 8'd50);
    checks++;
    if (setpoint_error !== 1'b1) begin
      errors++;
      $display("FAIL reject_pulse: setpoint_error=%b, required 1", setpoint_error);
    end
    tick();
    checks++;
    if (setpoint_error !== 1'b0 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL reject_single: setpoint_error=%b at_target=%b, required 0 1", setpoint_error, at_target);
    end
    n_inv = 0;
    n_err = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (invalidate_input_values === 1'b1) n_inv++;
      if (setpoint_error === 1'b1) n_err++;
    end
    checks++;
    if (n_inv != 0 || n_err != 0) begin
      errors++;
      $display("FAIL reject_no_update: invalidates=%0d errors=%0d, required 0 0", n_inv, n_err);
    end
    offer(8'd60, 8'd40);
    m_thi = 8'd60; m_tlo = 8'd40;
    checks++;
    if (setpoint_error !== 1'b0) begin
      errors++;
      $display("FAIL accept_sum_100: setpoint_error=%b, required 0", setpoint_error);
    end
    run_to_target(10);
  endtask

  task automatic test_enable_and_launch_cycle();
    int n_bad;
    bit found;
    upd_t a;
    enable = 1'b0;
    tick();
    offer(8'd10, 8'd10);
    m_thi = 8'd10; m_tlo = 8'd10;
    n_bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (tick_counter !== 8'd0 || invalidate_input_values !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad != 0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL enable_hold: bad_cycles=%0d at_target=%b, required 0 0", n_bad, at_target);
    end
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tick_counter == 8'd10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_tick10: not reached in 40 cycles, required reached");
      return;
    end
    push_next();
    offer(8'd20, 8'd20);
    checks++;
    if (invalidate_input_values !== 1'b1 || tick_counter !== 8'd11 || setpoint_error !== 1'b0) begin
      errors++;
      $display("FAIL launch_cycle_inv: inv=%b tick=%0d err=%b, required 1 11 0",
               invalidate_input_values, tick_counter, setpoint_error);
    end
    tick();
    a = exp_q.pop_front();
    checks++;
    if (load_input_values !== 1'b1 || tick_count_highside !== a.hs || tick_count_lowside !== a.ls) begin
      errors++;
      $display("FAIL launch_cycle_load: load=%b hs=%0d ls=%0d, required 1 %0d %0d",
               load_input_values, tick_count_highside, tick_count_lowside, a.hs, a.ls);
    end
    m_hs = a.hs; m_ls = a.ls;
    m_thi = 8'd20; m_tlo = 8'd20;
    complete_after(6);
    checks++;
    if (at_target !== 1'b0) begin
      errors++;
      $display("FAIL launch_cycle_deferred: at_target=%b, required 0", at_target);
    end
    run_to_target(20);
  endtask

  task automatic test_timeout();
    bit seen;
    upd_t a;
    offer(8'd30, 8'd30);
    m_thi = 8'd30; m_tlo = 8'd30;
    push_next();
    wait_invalidate(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_launch: no invalidate, required one");
      exp_q.delete();
      return;
    end
    tick();
    a = exp_q.pop_front();
    checks++;
    if (load_input_values !== 1'b1 || tick_count_highside !== a.hs || tick_count_lowside !== a.ls) begin
      errors++;
      $display("FAIL timeout_load: load=%b hs=%0d ls=%0d, required 1 %0d %0d",
               load_input_values, tick_count_highside, tick_count_lowside, a.hs, a.ls);
    end
    repeat (16) tick();
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: fault=%b busy=%b, required 0 1", fault, busy);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || tick_counter !== 8'd29 || tick_count_highside !== 8'd0 ||
        tick_count_lowside !== 8'd0 || setpoint_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: fault=%b tick=%0d hs=%0d ls=%0d ready=%b busy=%b, required 1 29 0 0 0 0",
               fault, tick_counter, tick_count_highside, tick_count_lowside, setpoint_ready, busy);
    end
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (fault !== 1'b0 || setpoint_ready !== 1'b1 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: fault=%b ready=%b at_target=%b, required 0 1 1",
               fault, setpoint_ready, at_target);
    end
    m_hs = '0; m_ls = '0; m_thi = '0; m_tlo = '0;
  endtask

  task automatic test_shortcircuit();
    bit seen;
    upd_t a;
    offer(8'd30, 8'd30);
    m_thi = 8'd30; m_tlo = 8'd30;
    push_next();
    wait_invalidate(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sc_launch: no invalidate, required one");
      exp_q.delete();
      return;
    end
    tick();
    a = exp_q.pop_front();
    checks++;
    if (tick_count_highside !== a.hs || tick_count_lowside !== a.ls) begin
      errors++;
      $display("FAIL sc_load: hs=%0d ls=%0d, required %0d %0d",
               tick_count_highside, tick_count_lowside, a.hs, a.ls);
    end
    repeat (2) tick();
    shortcircuit_error = 1'b1;
    tick();
    checks++;
    if (fault !== 1'b1 || tick_count_highside !== 8'd0 || tick_count_lowside !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sc_fault: fault=%b hs=%0d ls=%0d busy=%b, required 1 0 0 0",
               fault, tick_count_highside, tick_count_lowside, busy);
    end
    fault_clear = 1'b1;
    repeat (2) tick();
    checks++;
    if (fault !== 1'b1 || setpoint_ready !== 1'b0) begin
      errors++;
      $display("FAIL sc_clear_blocked: fault=%b ready=%b, required 1 0", fault, setpoint_ready);
    end
    shortcircuit_error = 1'b0;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (fault !== 1'b0 || setpoint_ready !== 1'b1) begin
      errors++;
      $display("FAIL sc_clear: fault=%b ready=%b, required 0 1", fault, setpoint_ready);
    end
    m_hs = '0; m_ls = '0; m_thi = '0; m_tlo = '0;
  endtask

  task automatic test_reset_in_load();
    bit seen;
    upd_t a;
    offer(8'd25, 8'd25);
    m_thi = 8'd25; m_tlo = 8'd25;
    push_next();
    wait_invalidate(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_launch: no invalidate, required one");
      exp_q.delete();
      return;
    end
    tick();
    a = exp_q.pop_front();
    checks++;
    if (load_input_values !== 1'b1 || tick_count_highside !== a.hs) begin
      errors++;
      $display("FAIL rst_load: load=%b hs=%0d, required 1 %0d", load_input_values, tick_count_highside, a.hs);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (tick_counter !== 8'd0 || tick_count_highside !== 8'd0 || tick_count_lowside !== 8'd0 ||
        load_input_values !== 1'b0 || invalidate_input_values !== 1'b0 || busy !== 1'b0 ||
        fault !== 1'b0 || setpoint_ready !== 1'b0 || at_target !== 1'b0 || setpoint_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tick=%0d hs=%0d ls=%0d load=%b busy=%b ready=%b, required all 0",
               tick_counter, tick_count_highside, tick_count_lowside, load_input_values, busy, setpoint_ready);
    end
    exp_q.delete();
    m_hs = '0; m_ls = '0; m_thi = '0; m_tlo = '0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    tick();
    checks++;
    if (setpoint_ready !== 1'b1 || busy !== 1'b0 || tick_counter !== 8'd1) begin
      errors++;
      $display("FAIL rst_release: ready=%b busy=%b tick=%0d, required 1 0 1", setpoint_ready, busy, tick_counter);
    end
    offer(8'd25, 8'd25);
    m_thi = 8'd25; m_tlo = 8'd25;
    run_to_target(10);
  endtask

  task automatic test_large_step();
    offer(8'd20, 8'd70);
    m_thi = 8'd20; m_tlo = 8'd70;
    checks++;
    if (setpoint_error !== 1'b0) begin
      errors++;
      $display("FAIL accept_20_70: setpoint_error=%b, required 0", setpoint_error);
    end
    run_to_target(25);
  endtask

  initial begin
    reset                = 1'b0;
    enable               = 1'b0;
    setpoint_valid       = 1'b0;
    setpoint_highside    = '0;
    setpoint_lowside     = '0;
    calculation_complete = 1'b0;
    calculation_error    = 1'b0;
    shortcircuit_error   = 1'b0;
    fault_clear          = 1'b0;
    test_reset();
    test_direct_update();
    test_reject();
    test_enable_and_launch_cycle();
    test_timeout();
    test_shortcircuit();
    test_reset_in_load();
    test_large_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
